// File: rtl/divider_reconstructor.sv
// divider_reconstructor: rebuilds a restoring-divider dividend as Q*D + R_n1 with an MSB-first
// shift-and-add, flagging dividend overflow and remainders that are illegal for the divisor.
module divider_reconstructor #(
    parameter int QW = 4,
    parameter int DW = 3,
    parameter int RW = 4,
    parameter int NW = 6,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [QW-1:0] Q,
    input  logic [DW-1:0] D,
    input  logic [RW-1:0] R_n1,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] R_0,
    output logic          ovf,
    output logic          rem_err
);
    localparam int CW = QW > 1 ? $clog2(QW) : 1;
    localparam int MW = RW > DW ? RW : DW;
    localparam longint MAX_FULL = (2**QW - 1) * (2**DW - 1) + (2**RW - 1);

    // The accumulator must hold the largest possible Q*D + R without wrapping.
    if (!(2.0**AW > MAX_FULL)) begin : g_aw_check
        $error("AW too small for QW/DW/RW");
    end

    typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

    state_t        state;
    logic [QW-1:0] qr;
    logic [DW-1:0] dr;
    logic [RW-1:0] rr;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [AW-1:0] full;

    assign full = acc + AW'(rr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            qr      <= '0;
            dr      <= '0;
            rr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            R_0     <= '0;
            ovf     <= 1'b0;
            rem_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    qr    <= Q;
                    dr    <= D;
                    rr    <= R_n1;
                    acc   <= '0;
                    cnt   <= CW'(QW - 1);
                    busy  <= 1'b1;
                    state <= MUL;
                end
                MUL: begin
                    acc <= (acc << 1) + (qr[cnt] ? AW'(dr) : '0);
                    if (cnt == '0) state <= ADD;
                    else cnt <= cnt - CW'(1);
                end
                ADD: begin
                    R_0     <= full[NW-1:0];
                    ovf     <= |full[AW-1:NW];
                    rem_err <= MW'(rr) >= MW'(dr);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_reconstructor.sv
// tb_divider_reconstructor: directed scenarios plus an exhaustive legal-operand sweep for
// the dividend reconstructor, checked against hand-computed and bench-computed values.
module tb_divider_reconstructor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] Q = '0;
    logic [2:0] D = '0;
    logic [3:0] R_n1 = '0;
    logic       busy, done, ovf, rem_err;
    logic [5:0] R_0;

    int tests = 0;
    int fails = 0;

    divider_reconstructor dut (
        .clk(clk), .rst(rst), .start(start), .Q(Q), .D(D), .R_n1(R_n1),
        .busy(busy), .done(done), .R_0(R_0), .ovf(ovf), .rem_err(rem_err)
    );

    always #5 clk = ~clk;

    // Launch one operation from just after an edge; returns latency in cycles and busy-cycle count.
    task automatic run_op(input logic [3:0] q, input logic [2:0] d, input logic [3:0] r,
                          output int lat, output int busy_cnt);
        Q = q; D = d; R_n1 = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, R_0, ovf, rem_err} !== 10'd0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b R_0=%0d ovf=%b rem_err=%b, want all 0",
                     busy, done, R_0, ovf, rem_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat, bc;
        run_op(4'd4, 3'd3, 4'd1, lat, bc);
        tests++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles, want 5", lat);
        end
        tests++;
        if (bc !== 5) begin
            fails++;
            $display("FAIL basic_busy_cycles: got %0d, want 5", bc);
        end
        tests++;
        if ({R_0, ovf, rem_err} !== {6'd13, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_result: got R_0=%0d ovf=%b rem_err=%b, want 13 0 0", R_0, ovf, rem_err);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || R_0 !== 6'd13) begin
            fails++;
            $display("FAIL basic_done_pulse: got done=%b R_0=%0d, want done=0 R_0=13", done, R_0);
        end
    endtask

    task automatic test_ovf;
        int lat, bc;
        run_op(4'd15, 3'd7, 4'd6, lat, bc);
        tests++;
        if (lat !== 5 || {R_0, ovf, rem_err} !== {6'd47, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL ovf_result: got lat=%0d R_0=%0d ovf=%b rem_err=%b, want 5 47 1 0",
                     lat, R_0, ovf, rem_err);
        end
    endtask

    task automatic test_rem_err;
        int lat, bc;
        run_op(4'd2, 3'd3, 4'd3, lat, bc);
        tests++;
        if (lat !== 5 || {R_0, ovf, rem_err} !== {6'd9, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL rem_err_eq: got lat=%0d R_0=%0d ovf=%b rem_err=%b, want 5 9 0 1",
                     lat, R_0, ovf, rem_err);
        end
        run_op(4'd5, 3'd0, 4'd2, lat, bc);
        tests++;
        if (lat !== 5 || {R_0, ovf, rem_err} !== {6'd2, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL rem_err_d0: got lat=%0d R_0=%0d ovf=%b rem_err=%b, want 5 2 0 1",
                     lat, R_0, ovf, rem_err);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        Q = 4'd3; D = 3'd5; R_n1 = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Q = 4'd2; D = 3'd1; R_n1 = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || R_0 !== 6'd19 || rem_err !== 1'b0) begin
            fails++;
            $display("FAIL busy_start_ignored: got done=%b R_0=%0d rem_err=%b, want 1 19 0", done, R_0, rem_err);
        end
        Q = 4'd1; D = 3'd1; R_n1 = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || R_0 !== 6'd19) begin
            fails++;
            $display("FAIL done_cycle_accept: got busy=%b done=%b R_0=%0d, want 1 0 19", busy, done, R_0);
        end
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 5 || R_0 !== 6'd1 || ovf !== 1'b0 || rem_err !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back_result: got lat=%0d R_0=%0d ovf=%b rem_err=%b, want 5 1 0 0",
                     lat, R_0, ovf, rem_err);
        end
    endtask

    task automatic test_reset_abort;
        int lat, bc;
        bit seen_done;
        Q = 4'd6; D = 3'd2; R_n1 = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, R_0, ovf, rem_err} !== 10'd0) begin
            fails++;
            $display("FAIL abort_async_clear: got busy=%b done=%b R_0=%0d ovf=%b rem_err=%b, want all 0",
                     busy, done, R_0, ovf, rem_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        tests++;
        if (seen_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: got activity after abort=1, want 0");
        end
        run_op(4'd6, 3'd2, 4'd1, lat, bc);
        tests++;
        if (lat !== 5 || {R_0, ovf, rem_err} !== {6'd13, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL abort_rerun: got lat=%0d R_0=%0d ovf=%b rem_err=%b, want 5 13 0 0",
                     lat, R_0, ovf, rem_err);
        end
    endtask

    // Every legal (Q, D, R_n1) pair: the dividend must divide back to the same quotient/remainder.
    task automatic test_sweep;
        int lat, bc, full, rq, rr;
        for (int d = 1; d < 8; d++) begin
            for (int q = 0; q < 16; q++) begin
                for (int r = 0; r < d; r++) begin
                    run_op(4'(q), 3'(d), 4'(r), lat, bc);
                    full = q * d + r;
                    rq = int'(R_0) / d;
                    rr = int'(R_0) % d;
                    tests++;
                    if (lat !== 5 || int'(R_0) !== full % 64 || ovf !== (full >= 64) || rem_err !== 1'b0 ||
                        (full < 64 && (rq !== q || rr !== r))) begin
                        fails++;
                        $display("FAIL sweep Q=%0d D=%0d R=%0d: got lat=%0d R_0=%0d ovf=%b rem_err=%b recovered %0d/%0d, want 5 %0d %b 0",
                                 q, d, r, lat, R_0, ovf, rem_err, rq, rr, full % 64, full >= 64);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ovf;
        test_rem_err;
        test_back_to_back;
        test_reset_abort;
        test_sweep;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
